// File: rtl/pkt_input_fifo_if.sv
// Handshake/status bundle for one ingress port of the packet-aware input FIFO.
// master drives writes and pops; slave is the FIFO itself.
interface pkt_input_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_eop;
  logic                  wr_en;
  logic                  wr_abort;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_count;
  logic                  ovf_drop;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_eop;
  logic                  rd_en;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_count;
  logic [ADDR_WIDTH:0]   pkt_count;

  modport master (
    output din, din_eop, wr_en, wr_abort, rd_en,
    input  full, almost_full, wr_count, ovf_drop, dout, dout_eop,
           empty, almost_empty, rd_count, pkt_count
  );

  modport slave (
    input  din, din_eop, wr_en, wr_abort, rd_en,
    output full, almost_full, wr_count, ovf_drop, dout, dout_eop,
           empty, almost_empty, rd_count, pkt_count
  );
endinterface

// File: rtl/pkt_input_fifo.sv
// Packet-aware input FIFO: words are written speculatively and only become readable
// once the packet's EOP word is accepted; aborted or overflowing packets are rewound.
//
// state       | meaning
// ST_ACCEPT   | words are stored at the speculative write pointer
// ST_DISCARD  | overflowed packet; ignore writes until its EOP word
module pkt_input_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int FWFT_EN       = 1,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 1
) (
  input  logic clk,
  input  logic rst_n,
  pkt_input_fifo_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic {ST_ACCEPT, ST_DISCARD} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         wptr_spec_q, wptr_spec_d;
  logic [PW-1:0]         wptr_cmt_q, wptr_cmt_d;
  logic [PW-1:0]         pkt_count_q, pkt_count_d;
  logic                  ovf_drop_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_eop_q;
  logic [DATA_WIDTH:0]   mem [DEPTH];

  logic                  wr_ok, rewind, ovf_d, commit, pop, pop_eop;
  logic [PW-1:0]         wr_cnt, rd_cnt, free_cnt;
  logic                  full, empty;
  logic [DATA_WIDTH:0]   mem_rd;

  assign wr_cnt   = wptr_spec_q - rptr_q;
  assign rd_cnt   = wptr_cmt_q - rptr_q;
  assign free_cnt = PW'(DEPTH) - wr_cnt;
  assign full     = (wr_cnt == PW'(DEPTH));
  assign empty    = (wptr_cmt_q == rptr_q);
  assign mem_rd   = mem[rptr_q[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACCEPT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.wr_abort) begin
      state_d = ST_ACCEPT;
    end else if (bus.wr_en) begin
      case (state_q)
        ST_ACCEPT:  if (full && !bus.din_eop) state_d = ST_DISCARD;
        ST_DISCARD: if (bus.din_eop)          state_d = ST_ACCEPT;
        default:    state_d = ST_ACCEPT;
      endcase
    end
  end

  // Abort outranks write; a write at full rewinds the open packet and flags overflow.
  always_comb begin
    wr_ok  = 1'b0;
    rewind = 1'b0;
    ovf_d  = 1'b0;
    if (bus.wr_abort) begin
      rewind = 1'b1;
    end else if (bus.wr_en && state_q == ST_ACCEPT) begin
      if (full) begin
        rewind = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        wr_ok = 1'b1;
      end
    end
  end

  assign commit  = wr_ok && bus.din_eop;
  assign pop     = bus.rd_en && !empty;
  assign pop_eop = pop && mem_rd[DATA_WIDTH];

  always_comb begin
    wptr_spec_d = wptr_spec_q;
    if (rewind)     wptr_spec_d = wptr_cmt_q;
    else if (wr_ok) wptr_spec_d = wptr_spec_q + 1'b1;
    wptr_cmt_d  = commit ? wptr_spec_q + 1'b1 : wptr_cmt_q;
    rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
    pkt_count_d = pkt_count_q;
    if (commit && !pop_eop)      pkt_count_d = pkt_count_q + 1'b1;
    else if (!commit && pop_eop) pkt_count_d = pkt_count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q      <= '0;
      wptr_spec_q <= '0;
      wptr_cmt_q  <= '0;
      pkt_count_q <= '0;
      ovf_drop_q  <= 1'b0;
      dout_q      <= '0;
      dout_eop_q  <= 1'b0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_spec_q <= wptr_spec_d;
      wptr_cmt_q  <= wptr_cmt_d;
      pkt_count_q <= pkt_count_d;
      ovf_drop_q  <= ovf_d;
      if (pop) begin
        dout_q     <= mem_rd[DATA_WIDTH-1:0];
        dout_eop_q <= mem_rd[DATA_WIDTH];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_spec_q[ADDR_WIDTH-1:0]] <= {bus.din_eop, bus.din};
  end

  // In FWFT mode dout_q keeps the last popped word for display while empty.
  assign bus.dout         = (FWFT_EN != 0 && !empty) ? mem_rd[DATA_WIDTH-1:0] : dout_q;
  assign bus.dout_eop     = (FWFT_EN != 0 && !empty) ? mem_rd[DATA_WIDTH] : dout_eop_q;
  assign bus.full         = full;
  assign bus.almost_full  = (free_cnt <= PW'(AFULL_MARGIN)) || full;
  assign bus.empty        = empty;
  assign bus.almost_empty = (rd_cnt <= PW'(AEMPTY_MARGIN)) || empty;
  assign bus.wr_count     = wr_cnt;
  assign bus.rd_count     = rd_cnt;
  assign bus.pkt_count    = pkt_count_q;
  assign bus.ovf_drop     = ovf_drop_q;
endmodule

// File: doc/pkt_input_fifo.md
# pkt_input_fifo

Packet-aware synchronous input FIFO for each ingress port of the multi-port cache. Words are written speculatively and become visible to the reader only when the packet's last word (EOP) is accepted. A packet can be aborted by the writer or dropped automatically on overflow, so downstream logic only ever sees whole packets. Supports first-word-fall-through (FWFT) or registered-read mode, programmable almost-flag margins and occupancy/packet counters.

## Interface
- DATA_WIDTH, 32, payload width
- ADDR_WIDTH, 5, log2 depth; DEPTH = 2**ADDR_WIDTH
- FWFT_EN, 1, 1 = first-word-fall-through, 0 = registered read
- AFULL_MARGIN, 2, almost_full when free entries <= AFULL_MARGIN
- AEMPTY_MARGIN, 1, almost_empty when readable entries <= AEMPTY_MARGIN
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- din  in  DATA_WIDTH  write data
- din_eop  in  1  marks last word of packet
- wr_en  in  1  write request
- wr_abort  in  1  discard the packet currently being written
- full  out  1  no free entry (committed + speculative)
- almost_full  out  1  free entries <= AFULL_MARGIN
- wr_count  out  ADDR_WIDTH+1  entries used, including uncommitted
- ovf_drop  out  1  one-cycle pulse: packet dropped by overflow
- dout  out  DATA_WIDTH  read data
- dout_eop  out  1  EOP flag of the word on dout
- rd_en  in  1  pop request
- empty  out  1  no committed entry
- almost_empty  out  1  committed entries <= AEMPTY_MARGIN
- rd_count  out  ADDR_WIDTH+1  committed unread entries
- pkt_count  out  ADDR_WIDTH+1  complete packets held

## Operation
- Storage: DEPTH x (DATA_WIDTH+1) array; the extra bit stores EOP.
- Pointers: rptr, wptr_spec, wptr_cmt. Each is ADDR_WIDTH+1 bits wide and wraps modulo 2*DEPTH. The MSB distinguishes full from empty.
- full = (wptr_spec - rptr) == DEPTH. empty = (wptr_cmt == rptr).
- wr_count = wptr_spec - rptr. rd_count = wptr_cmt - rptr.
- Write FSM, two states:
  - ACCEPT:
    - wr_en & ~full: store {din_eop, din} at wptr_spec; wptr_spec++. If din_eop: wptr_cmt <= new wptr_spec; pkt_count++.
    - wr_en & full: overflow. wptr_spec <= wptr_cmt; ovf_drop = 1. Go to DISCARD, unless din_eop = 1, in which case stay in ACCEPT.
  - DISCARD:
    - All writes ignored.
    - wr_en & din_eop: go to ACCEPT. No further pulse.
- wr_abort has priority over wr_en in the same cycle and is legal in either state:
  - wptr_spec <= wptr_cmt; the word presented that cycle is not written; FSM goes to ACCEPT.
  - ovf_drop is not asserted.
- A packet longer than DEPTH - rd_count always overflows and is dropped.
- Read: rd_en & ~empty pops; rptr++. If the popped word has EOP set, pkt_count--. rd_en while empty is ignored.
- When a commit and an EOP pop happen in the same cycle, pkt_count is unchanged.
- Almost flags:
  - almost_full = (DEPTH - wr_count) <= AFULL_MARGIN, or full.
  - almost_empty = rd_count <= AEMPTY_MARGIN, or empty.
- All status outputs are decoded from registered state only. There is no combinational path from any input to any status output.

## Timing
- Reset values: empty=1, almost_empty=1, full=0, almost_full=0, wr_count=0, rd_count=0, pkt_count=0, ovf_drop=0, dout=0, dout_eop=0. FSM resets to ACCEPT.
- Reset is asynchronous and may occur mid-packet. All pointers clear and partial packets are lost. Array contents are not reset.
- Commit latency: EOP accepted at edge N → empty falls and rd_count/pkt_count update after edge N.
- FWFT_EN=1:
  - While ~empty, dout/dout_eop show mem[rptr] combinationally. The word is first valid the cycle after it is committed.
  - While empty, dout holds the last popped word.
- FWFT_EN=0: dout/dout_eop are registered and load mem[rptr] on the edge where rd_en & ~empty. Otherwise they hold their value.
- Read and write in the same cycle are allowed at any occupancy, including full and empty. A write at full is an overflow even if a pop occurs in that cycle.
- ovf_drop asserts in the cycle after the overflowing edge and lasts exactly one cycle.

## Test plan
- Reset, then write a 3-word packet A0..A2 with EOP on A2 (FWFT=1) → empty stays 1 until after the A2 edge; then dout=A0; three pops give A0, A1, A2 with dout_eop only on A2; pkt_count goes 1→0.
- Write 2 words, assert wr_abort, then write a 1-word packet B (EOP) → rd_count=1, dout=B, ovf_drop stays 0.
- DEPTH=32: hold 30 committed words, then write a 4-word packet → overflow on the 3rd word; ovf_drop pulses once; the 4th (EOP) word is swallowed; wr_count returns to 30.
- Fill to exactly 32 committed words → full=1, almost_full=1. Pop and push simultaneously → push is dropped as overflow; rd_count=31.
- FWFT=0: commit packet C0,C1; rd_en in two consecutive cycles → dout=C0 one edge after the first rd_en and C1 after the second; dout holds C1 afterwards.
- Stream 100 single-word packets with random rd_en over 3+ pointer wraps → output order matches input, no loss while never full, and pkt_count == rd_count throughout.
